// File: rtl/hz_bram_port_cntlr.sv
// ---------------------------------------------------------------------------
// hz_bram_port_cntlr
//   Single-port bus-to-BRAM controller for port A of the local BRAM block.
//   It accepts one request at a time on a valid/ready request channel and
//   decodes the address against the C_BASEADDR..C_HIGHADDR window. A hit
//   issues a registered one-cycle BRAM access, and a miss returns an error.
//   Responses are returned on a valid/ready response channel.
//
//   Build option: define HZ_BRAM_CNTLR_WR_RSP_EN to make write hits return a
//   response. When it is undefined, write hits are posted and get no response.
//
// Ports (big-endian bit numbering, bit 0 = MSB):
//   LMB_Clk, LMB_Rst          clock, synchronous active-high reset
//   Req_Valid/Req_Ready       request handshake
//   Req_Write                 1 = write, 0 = read
//   Req_Addr[0:31]            byte address (bits 30:31 ignored)
//   Req_BE[0:3]               byte enables, BE[0] -> data bits 0:7
//   Req_WData[0:31]           write data
//   Rsp_Valid/Rsp_Ready       response handshake
//   Rsp_Data[0:31]            read data (0 for writes/errors)
//   Rsp_Err                   address outside window
//   BRAM_*_A                  BRAM port A (EN/WEN/Addr/Dout registered)
// ---------------------------------------------------------------------------
module hz_bram_port_cntlr #(
    parameter logic [31:0] C_BASEADDR    = 32'h0000_0000,
    parameter logic [31:0] C_HIGHADDR    = 32'h0000_1FFF,
    parameter int unsigned C_PORT_DWIDTH = 32,
    parameter int unsigned C_NUM_WE      = 4
) (
    input  logic                     LMB_Clk,
    input  logic                     LMB_Rst,
    input  logic                     Req_Valid,
    output logic                     Req_Ready,
    input  logic                     Req_Write,
    input  logic [0:31]              Req_Addr,
    input  logic [0:C_NUM_WE-1]      Req_BE,
    input  logic [0:C_PORT_DWIDTH-1] Req_WData,
    output logic                     Rsp_Valid,
    input  logic                     Rsp_Ready,
    output logic [0:C_PORT_DWIDTH-1] Rsp_Data,
    output logic                     Rsp_Err,
    output logic                     BRAM_Rst_A,
    output logic                     BRAM_Clk_A,
    output logic                     BRAM_EN_A,
    output logic [0:C_NUM_WE-1]      BRAM_WEN_A,
    output logic [0:31]              BRAM_Addr_A,
    output logic [0:C_PORT_DWIDTH-1] BRAM_Dout_A,
    input  logic [0:C_PORT_DWIDTH-1] BRAM_Din_A
);

    localparam logic [31:0] WIN_MASK  = C_HIGHADDR - C_BASEADDR;
    // Offset within the window, forced to a word boundary.
    localparam logic [31:0] ADDR_MASK = WIN_MASK & 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RD_CAPT,
        RESP
    } state_t;

    state_t state, state_nxt;

    logic                     is_write;
    logic                     en_q;
    logic [0:C_NUM_WE-1]      wen_q;
    logic [0:31]              addr_q;
    logic [0:C_PORT_DWIDTH-1] dout_q;
    logic [0:C_PORT_DWIDTH-1] rsp_data_q;
    logic                     rsp_err_q;

    logic req_fire;
    logic hit;

    assign hit      = ((Req_Addr & ~WIN_MASK) == C_BASEADDR);
    assign req_fire = Req_Valid && (state == IDLE);

    always_comb begin
        state_nxt = state;
        Req_Ready = 1'b0;
        Rsp_Valid = 1'b0;
        case (state)
            IDLE: begin
                Req_Ready = 1'b1;
                if (Req_Valid) state_nxt = hit ? ACCESS : RESP;
            end
            ACCESS: begin
                if (!is_write) begin
                    state_nxt = RD_CAPT;
                end else begin
`ifdef HZ_BRAM_CNTLR_WR_RSP_EN
                    state_nxt = RESP;
`else
                    state_nxt = IDLE;
`endif
                end
            end
            RD_CAPT: state_nxt = RESP;
            RESP: begin
                Rsp_Valid = 1'b1;
                if (Rsp_Ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge LMB_Clk) begin
        if (LMB_Rst) begin
            state      <= IDLE;
            is_write   <= 1'b0;
            en_q       <= 1'b0;
            wen_q      <= '0;
            addr_q     <= '0;
            dout_q     <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            // The strobes are pulses. They are set only on an accepted hit.
            en_q  <= 1'b0;
            wen_q <= '0;
            if (req_fire) begin
                is_write   <= Req_Write;
                rsp_data_q <= '0;
                rsp_err_q  <= !hit;
                if (hit) begin
                    en_q   <= 1'b1;
                    wen_q  <= Req_Write ? Req_BE : '0;
                    addr_q <= Req_Addr & ADDR_MASK;
                    if (Req_Write) dout_q <= Req_WData;
                end
            end
            // BRAM read data is valid in the cycle after EN.
            if (state == RD_CAPT) rsp_data_q <= BRAM_Din_A;
        end
    end

    assign Rsp_Data    = rsp_data_q;
    assign Rsp_Err     = rsp_err_q;
    assign BRAM_Rst_A  = LMB_Rst;
    assign BRAM_Clk_A  = LMB_Clk;
    assign BRAM_EN_A   = en_q;
    assign BRAM_WEN_A  = wen_q;
    assign BRAM_Addr_A = addr_q;
    assign BRAM_Dout_A = dout_q;

endmodule

// File: tb/tb_hz_bram_port_cntlr.sv
// ---------------------------------------------------------------------------
// tb_hz_bram_port_cntlr
//   Directed, table-driven bench for hz_bram_port_cntlr with a behavioural
//   BRAM on port A. It follows HZ_BRAM_CNTLR_WR_RSP_EN the same way the DUT
//   does.
// ---------------------------------------------------------------------------
module tb_hz_bram_port_cntlr;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write;
    logic [0:31] req_addr, req_wdata;
    logic [0:3]  req_be;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [0:31] rsp_data;
    logic        bram_rst, bram_clk, bram_en;
    logic [0:3]  bram_wen;
    logic [0:31] bram_addr, bram_dout;
    logic [0:31] bram_din;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hz_bram_port_cntlr dut (
        .LMB_Clk    (clk),
        .LMB_Rst    (rst),
        .Req_Valid  (req_valid),
        .Req_Ready  (req_ready),
        .Req_Write  (req_write),
        .Req_Addr   (req_addr),
        .Req_BE     (req_be),
        .Req_WData  (req_wdata),
        .Rsp_Valid  (rsp_valid),
        .Rsp_Ready  (rsp_ready),
        .Rsp_Data   (rsp_data),
        .Rsp_Err    (rsp_err),
        .BRAM_Rst_A (bram_rst),
        .BRAM_Clk_A (bram_clk),
        .BRAM_EN_A  (bram_en),
        .BRAM_WEN_A (bram_wen),
        .BRAM_Addr_A(bram_addr),
        .BRAM_Dout_A(bram_dout),
        .BRAM_Din_A (bram_din)
    );

    // Behavioural 8 KB BRAM: synchronous, read-before-write, big-endian lanes.
    logic [0:31] mem [0:2047];
    logic [31:0] bram_addr_le;
    assign bram_addr_le = bram_addr;

    always @(posedge clk) begin
        if (bram_en) begin
            bram_din <= mem[bram_addr_le[12:2]];
            for (int b = 0; b < 4; b++)
                if (bram_wen[b]) mem[bram_addr_le[12:2]][8*b +: 8] <= bram_dout[8*b +: 8];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        hit;
        logic [31:0] exp_addr;
        logic [31:0] exp_data;
    } vec_t;

    // Complete the response handshake from a negedge where Rsp_Valid is high.
    task automatic respond();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        chk("rsp_valid_drop", rsp_valid, 1'b0);
        chk("req_ready_after_rsp", req_ready, 1'b1);
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        chk("req_ready_idle", req_ready, 1'b1);
        req_valid = 1'b1;
        req_write = v.wr;
        req_addr  = v.addr;
        req_be    = v.be;
        req_wdata = v.wdata;
        @(posedge clk);
        // Scramble the request lines after the handshake. The DUT must ignore them.
        #1;
        req_valid = 1'b0;
        req_write = ~v.wr;
        req_addr  = 32'hFFFF_FFF0;
        req_be    = 4'hF;
        req_wdata = $urandom;
        @(negedge clk);  // N+1
        if (v.hit) begin
            chk("n1_en", bram_en, 1'b1);
            chk("n1_wen", bram_wen, v.wr ? v.be : 4'h0);
            chk("n1_addr", bram_addr, v.exp_addr);
            if (v.wr) chk("n1_dout", bram_dout, v.wdata);
            chk("n1_rsp_valid", rsp_valid, 1'b0);
            @(negedge clk);  // N+2
            chk("n2_en_pulse", bram_en, 1'b0);
            chk("n2_wen_pulse", bram_wen, 4'h0);
            if (!v.wr) begin
                chk("n2_rsp_valid", rsp_valid, 1'b0);
                chk("n2_req_ready", req_ready, 1'b0);
                @(negedge clk);  // N+3
                chk("rd_rsp_valid", rsp_valid, 1'b1);
                chk("rd_rsp_err", rsp_err, 1'b0);
                chk("rd_rsp_data", rsp_data, v.exp_data);
                respond();
            end else begin
`ifdef HZ_BRAM_CNTLR_WR_RSP_EN
                chk("wr_rsp_valid", rsp_valid, 1'b1);
                chk("wr_rsp_err", rsp_err, 1'b0);
                chk("wr_rsp_data", rsp_data, 32'h0);
                respond();
`else
                chk("wr_posted_no_rsp", rsp_valid, 1'b0);
                chk("wr_posted_ready", req_ready, 1'b1);
`endif
            end
        end else begin
            chk("miss_no_en", bram_en, 1'b0);
            chk("miss_rsp_valid", rsp_valid, 1'b1);
            chk("miss_rsp_err", rsp_err, 1'b1);
            chk("miss_rsp_data", rsp_data, 32'h0);
            respond();
        end
    endtask

    vec_t vecs [12];

    initial begin
        logic [31:0] held_data;
        logic        held_err;

        vecs[0]  = '{1'b1, 32'h0000_1000, 4'b1111, 32'hDEAD_BEEF, 1'b1, 32'h0000_1000, 32'h0};
        vecs[1]  = '{1'b0, 32'h0000_1000, 4'b0000, 32'h0,         1'b1, 32'h0000_1000, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 32'h0000_1000, 4'b0100, 32'h00AA_0000, 1'b1, 32'h0000_1000, 32'h0};
        vecs[3]  = '{1'b0, 32'h0000_1000, 4'b0000, 32'h0,         1'b1, 32'h0000_1000, 32'hDEAA_BEEF};
        vecs[4]  = '{1'b0, 32'h0000_2000, 4'b0000, 32'h0,         1'b0, 32'h0,         32'h0};
        vecs[5]  = '{1'b1, 32'h0000_0004, 4'b0011, 32'h1234_5678, 1'b1, 32'h0000_0004, 32'h0};
        vecs[6]  = '{1'b0, 32'h0000_0006, 4'b0000, 32'h0,         1'b1, 32'h0000_0004, 32'h0000_5678};
        vecs[7]  = '{1'b1, 32'h0000_1FFC, 4'b1001, 32'hA1B2_C3D4, 1'b1, 32'h0000_1FFC, 32'h0};
        vecs[8]  = '{1'b0, 32'h0000_1FFF, 4'b0000, 32'h0,         1'b1, 32'h0000_1FFC, 32'hA100_00D4};
        vecs[9]  = '{1'b1, 32'hFFFF_0000, 4'b1111, 32'h5555_5555, 1'b0, 32'h0,         32'h0};
        vecs[10] = '{1'b1, 32'h0000_0008, 4'b0000, 32'hFFFF_FFFF, 1'b1, 32'h0000_0008, 32'h0};
        vecs[11] = '{1'b0, 32'h0000_0008, 4'b0000, 32'h0,         1'b1, 32'h0000_0008, 32'h0};

        for (int i = 0; i < 2048; i++) mem[i] = '0;
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_be = '0; req_wdata = '0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_err", rsp_err, 1'b0);
        chk("rst_rsp_data", rsp_data, 32'h0);
        chk("rst_en", bram_en, 1'b0);
        chk("rst_wen", bram_wen, 4'h0);
        chk("rst_addr", bram_addr, 32'h0);
        chk("rst_dout", bram_dout, 32'h0);

        foreach (vecs[i]) apply(vecs[i]);

        // The response is held under backpressure, and a competing request stays blocked.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_1000; req_be = 4'h0;
        @(posedge clk);
        #1 req_addr = 32'h0000_0004;  // leave valid high: must not be accepted
        repeat (2) @(negedge clk);
        @(negedge clk);  // N+3
        chk("bp_rsp_valid", rsp_valid, 1'b1);
        chk("bp_rsp_data", rsp_data, 32'hDEAA_BEEF);
        held_data = rsp_data;
        held_err  = rsp_err;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_hold_valid", rsp_valid, 1'b1);
            chk("bp_hold_data", rsp_data, held_data);
            chk("bp_hold_err", rsp_err, held_err);
            chk("bp_req_ready", req_ready, 1'b0);
            chk("bp_no_en", bram_en, 1'b0);
        end
        req_valid = 1'b0;
        respond();

        // Reset while in RD_CAPT drops the read.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_1000;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);  // N+1 ACCESS
        @(negedge clk);  // N+2 RD_CAPT
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_rsp_valid", rsp_valid, 1'b0);
        chk("mid_rst_rsp_data", rsp_data, 32'h0);
        chk("mid_rst_rsp_err", rsp_err, 1'b0);
        chk("mid_rst_en", bram_en, 1'b0);
        chk("mid_rst_addr", bram_addr, 32'h0);
        chk("mid_rst_dout", bram_dout, 32'h0);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("post_rst_no_rsp", rsp_valid, 1'b0);
            chk("post_rst_no_en", bram_en, 1'b0);
            chk("post_rst_ready", req_ready, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
